// File: rtl/payload_char_feeder_if.sv
// Payload byte stream between the packet pipeline (master) and the
// character feeder (slave).
interface payload_char_feeder_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;

    modport master (
        output s_data,
        output s_valid,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/payload_char_feeder.sv
// Turns the payload byte stream into sod/en/cls/eop strobes for the engine array.
// Optional macro PAYLOAD_CHAR_FEEDER_CASE_FOLD_EN folds A-Z to a-z before the class lookup.
module payload_char_feeder #(
    parameter int NUM_CLASSES = 38,
    parameter int MAX_BYTES   = 1518,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    payload_char_feeder_if.slave     s_if,
    input  logic                     cfg_we,
    input  logic [5:0]               cfg_class,
    input  logic [7:0]               cfg_char,
    input  logic                     cfg_val,
    output logic                     sod,
    output logic                     en,
    output logic [NUM_CLASSES-1:0]   cls,
    output logic                     eop,
    output logic                     trunc,
    output logic [CNT_W-1:0]         byte_cnt
);

    localparam int                 ROW_W     = NUM_CLASSES - 1;
    localparam logic [6:0]         CLS_LIMIT = 7'(NUM_CLASSES);
    localparam logic [CNT_W-1:0]   MAX_CNT   = CNT_W'(MAX_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SOD  = 3'd1,
        ST_LS   = 3'd2,
        ST_DATA = 3'd3,
        ST_EOP  = 3'd4,
        ST_DROP = 3'd5
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;

    logic                   sod_r;
    logic                   en_r;
    logic [NUM_CLASSES-1:0] cls_r;
    logic                   eop_r;
    logic                   trunc_r;
    logic [CNT_W-1:0]       byte_cnt_r;
    logic                   s_ready_r;

    logic                   sod_nxt_s;
    logic                   en_nxt_s;
    logic [NUM_CLASSES-1:0] cls_nxt_s;
    logic                   eop_nxt_s;
    logic                   trunc_nxt_s;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   s_ready_nxt_s;

    logic                   drop_r;
    logic                   pkt_open_r;

    logic                   accept_s;
    logic                   strobe_s;
    logic [CNT_W-1:0]       cnt_inc_s;
    logic [7:0]             lookup_byte_s;
    logic [ROW_W-1:0]       row_s;
    logic                   cfg_hit_s;
    logic [5:0]             cfg_bit_s;

    logic [ROW_W-1:0]       table_r [256];

    assign accept_s  = s_if.s_valid && s_ready_r;
    assign strobe_s  = (byte_cnt_r < MAX_CNT);
    assign cnt_inc_s = (byte_cnt_r == {CNT_W{1'b1}}) ? byte_cnt_r : (byte_cnt_r + CNT_W'(1));

    // Class 0 is the hardwired line-start symbol, so table bit k-1 holds class k.
    assign cfg_hit_s = cfg_we && (cfg_class != 6'd0) && ({1'b0, cfg_class} < CLS_LIMIT);
    assign cfg_bit_s = cfg_class - 6'd1;

`ifdef PAYLOAD_CHAR_FEEDER_CASE_FOLD_EN
    function automatic logic [7:0] fold_byte(input logic [7:0] b);
        if ((b >= 8'h41) && (b <= 8'h5A)) begin
            return b | 8'h20;
        end else begin
            return b;
        end
    endfunction

    assign lookup_byte_s = fold_byte(s_if.s_data);
`else
    assign lookup_byte_s = s_if.s_data;
`endif

    // A same-cycle write lands after this read, so a colliding lookup sees the old row.
    assign row_s = table_r[lookup_byte_s];

    // Class table write port; deliberately not reset so programming survives reset.
    always_ff @(posedge clk) begin
        if (cfg_hit_s) begin
            table_r[cfg_char][cfg_bit_s] <= cfg_val;
        end
    end

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_nxt_s = state_r;
        sod_nxt_s   = 1'b0;
        en_nxt_s    = 1'b0;
        cls_nxt_s   = '0;
        eop_nxt_s   = 1'b0;
        trunc_nxt_s = trunc_r;
        cnt_nxt_s   = byte_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (s_if.s_valid) begin
                    if (drop_r) begin
                        state_nxt_s = ST_DROP;
                    end else begin
                        state_nxt_s = ST_SOD;
                        cnt_nxt_s   = '0;
                        trunc_nxt_s = 1'b0;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SOD: begin
                sod_nxt_s   = 1'b1;
                state_nxt_s = ST_LS;
            end
            ST_LS: begin
                en_nxt_s    = 1'b1;
                cls_nxt_s   = NUM_CLASSES'(1);
                state_nxt_s = ST_DATA;
            end
            ST_DATA: begin
                if (accept_s) begin
                    cnt_nxt_s = cnt_inc_s;
                    if (strobe_s) begin
                        en_nxt_s  = 1'b1;
                        cls_nxt_s = {row_s, 1'b0};
                    end else begin
                        trunc_nxt_s = 1'b1;
                    end
                    // A newline only opens a new line if it was actually stepped.
                    if (s_if.s_last) begin
                        state_nxt_s = ST_EOP;
                    end else if ((s_if.s_data == 8'h0A) && strobe_s) begin
                        state_nxt_s = ST_LS;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_EOP: begin
                eop_nxt_s   = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            ST_DROP: begin
                if (accept_s && s_if.s_last) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign s_ready_nxt_s = (state_nxt_s == ST_DATA) || (state_nxt_s == ST_DROP);

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            sod_r      <= 1'b0;
            en_r       <= 1'b0;
            cls_r      <= '0;
            eop_r      <= 1'b0;
            trunc_r    <= 1'b0;
            byte_cnt_r <= '0;
            s_ready_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            sod_r      <= sod_nxt_s;
            en_r       <= en_nxt_s;
            cls_r      <= cls_nxt_s;
            eop_r      <= eop_nxt_s;
            trunc_r    <= trunc_nxt_s;
            byte_cnt_r <= cnt_nxt_s;
            s_ready_r  <= s_ready_nxt_s;
        end
    end

    // Drop bookkeeping outlives reset so the tail of a packet cut by reset is flushed.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_r     <= drop_r | pkt_open_r;
            pkt_open_r <= 1'b0;
        end else begin
            if (accept_s && s_if.s_last) begin
                drop_r     <= 1'b0;
                pkt_open_r <= 1'b0;
            end else if ((state_r == ST_IDLE) && (state_nxt_s == ST_SOD)) begin
                drop_r     <= drop_r;
                pkt_open_r <= 1'b1;
            end else begin
                drop_r     <= drop_r;
                pkt_open_r <= pkt_open_r;
            end
        end
    end

    assign sod          = sod_r;
    assign en           = en_r;
    assign cls          = cls_r;
    assign eop          = eop_r;
    assign trunc        = trunc_r;
    assign byte_cnt     = byte_cnt_r;
    assign s_if.s_ready = s_ready_r;

endmodule

// File: tb/tb_payload_char_feeder.sv
// Directed bench for payload_char_feeder (MAX_BYTES reduced to 4 for truncation).
module tb_payload_char_feeder;

    localparam int NC   = 38;
    localparam int MAXB = 4;
    localparam int CW   = 16;

    localparam logic [NC-1:0] C_LS = 38'h1;
    localparam logic [NC-1:0] C_X  = 38'h20_0000_0000;
    localparam logic [NC-1:0] C_Y  = 38'h8;
    localparam logic [NC-1:0] C_C  = 38'h2;
    localparam logic [NC-1:0] C_Z  = 38'h0;
`ifdef PAYLOAD_CHAR_FEEDER_CASE_FOLD_EN
    localparam logic [NC-1:0] C_A    = 38'h80;
    localparam logic [63:0]   EXP_C7 = 64'd1;
`else
    localparam logic [NC-1:0] C_A    = 38'h20;
    localparam logic [63:0]   EXP_C7 = 64'd0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_we;
    logic [5:0]    cfg_class;
    logic [7:0]    cfg_char;
    logic          cfg_val;
    logic          sod, en, eop, trunc;
    logic [NC-1:0] cls;
    logic [CW-1:0] byte_cnt;

    payload_char_feeder_if sif();

    payload_char_feeder #(.NUM_CLASSES(NC), .MAX_BYTES(MAXB), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .s_if(sif),
        .cfg_we(cfg_we), .cfg_class(cfg_class), .cfg_char(cfg_char), .cfg_val(cfg_val),
        .sod(sod), .en(en), .cls(cls), .eop(eop), .trunc(trunc), .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int cyc = 0, sod_n, sod_cyc, en_n, first_en, last_en, eop_n, eop_cyc, overlap, leak, nl_n, nl_rdy;
    logic          eop_trunc;
    logic [CW-1:0] eop_cnt;
    logic [NC-1:0] en_q[$];
    logic [NC-1:0] exp_q[$];
    logic          nl_acc_r = 1'b0;
    logic [7:0]    pkt [16];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk)
        nl_acc_r <= sif.s_valid && sif.s_ready && (sif.s_data == 8'h0A) && !sif.s_last;

    always @(negedge clk) begin
        cyc++;
        if (sod) begin sod_n++; sod_cyc = cyc; end
        if (en) begin
            en_q.push_back(cls);
            if (en_n == 0) first_en = cyc;
            last_en = cyc;
            en_n++;
        end
        if (sod && en) overlap++;
        if (!en && (cls != '0)) leak++;
        if (eop) begin eop_n++; eop_cyc = cyc; eop_trunc = trunc; eop_cnt = byte_cnt; end
        if (nl_acc_r) begin nl_n++; if (sif.s_ready) nl_rdy++; end
    end

    task automatic clear_mon();
        sod_n = 0; sod_cyc = 0; en_n = 0; first_en = 0; last_en = 0; eop_n = 0; eop_cyc = 0;
        overlap = 0; leak = 0; nl_n = 0; nl_rdy = 0; eop_trunc = 1'b0; eop_cnt = '0;
        en_q.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [5:0] k, input logic [7:0] b, input logic v);
        cfg_we = 1'b1; cfg_class = k; cfg_char = b; cfg_val = v;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic check_quiet(input string nm);
        check_eq({nm, "_ctl"}, 64'({sod, en, eop, trunc, sif.s_ready}), 64'd0);
        check_eq({nm, "_cls"}, 64'(cls), 64'd0);
        check_eq({nm, "_cnt"}, 64'(byte_cnt), 64'd0);
    endtask

    // Sends pkt[0..len-1]; gap idle cycles after each byte; reset while byte rst_at is presented.
    task automatic run_pkt(input int len, input int gap, input int rst_at);
        int  guard;
        logic acc;
        for (int i = 0; i < len; i++) begin
            sif.s_valid = 1'b1; sif.s_data = pkt[i]; sif.s_last = (i == len - 1);
            if (i == rst_at) begin
                reset = 1'b1;
                @(negedge clk);
                check_quiet("rst_mid");
                tick();
                reset = 1'b0;
                clear_mon();
            end
            guard = 0; acc = 1'b0;
            while (!acc && guard < 200) begin
                @(negedge clk);
                acc = sif.s_ready;
                tick();
                guard++;
            end
            if (!acc) check_eq("hs_timeout", 64'd0, 64'd1);
            sif.s_valid = 1'b0; sif.s_last = 1'b0;
            for (int g = 0; g < gap; g++) tick();
        end
    endtask

    task automatic wait_eop();
        int g = 0;
        while (eop_n == 0 && g < 60) begin tick(); g++; end
        if (eop_n == 0) check_eq("eop_timeout", 64'd0, 64'd1);
        repeat (2) tick();
    endtask

    task automatic check_seq(input string nm);
        check_eq({nm, "_en_n"}, 64'(en_n), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++)
            if (k < en_q.size()) check_eq($sformatf("%s_cls%0d", nm, k), 64'(en_q[k]), 64'(exp_q[k]));
        check_eq({nm, "_sod_n"}, 64'(sod_n), 64'd1);
        check_eq({nm, "_sod_en"}, 64'(overlap), 64'd0);
        check_eq({nm, "_leak"}, 64'(leak), 64'd0);
    endtask

    initial begin
        logic [7:0] clr [8];
        clr[0] = 8'h41; clr[1] = 8'h42; clr[2] = 8'h61; clr[3] = 8'h62;
        clr[4] = 8'h78; clr[5] = 8'h79; clr[6] = 8'h0A; clr[7] = 8'h63;
        reset = 1'b1; cfg_we = 1'b0; cfg_class = 6'd0; cfg_char = 8'h00; cfg_val = 1'b0;
        sif.s_valid = 1'b0; sif.s_data = 8'h00; sif.s_last = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        tick();
        reset = 1'b0;

        for (int b = 0; b < 8; b++)
            for (int k = 1; k < NC; k++) cfg_write(6'(k), clr[b], 1'b0);
        cfg_write(6'd5, 8'h41, 1'b1);
        cfg_write(6'd7, 8'h61, 1'b1);
        cfg_write(6'd37, 8'h78, 1'b1);
        cfg_write(6'd3, 8'h79, 1'b1);
        cfg_write(6'd1, 8'h63, 1'b1);
        cfg_write(6'd0, 8'h42, 1'b1);
        cfg_write(6'd38, 8'h42, 1'b1);
        repeat (2) tick();

        // Basic packet "A","B"
        clear_mon();
        pkt[0] = 8'h41; pkt[1] = 8'h42;
        run_pkt(2, 0, -1); wait_eop();
        exp_q = '{C_LS, C_A, C_Z};
        check_seq("basic");
        check_eq("basic_sod_lead", 64'(first_en - sod_cyc), 64'd1);
        check_eq("basic_eop_after", 64'(eop_cyc > last_en), 64'd1);
        check_eq("basic_eop_n", 64'(eop_n), 64'd1);
        check_eq("basic_trunc", 64'(eop_trunc), 64'd0);
        check_eq("basic_cnt", 64'(eop_cnt), 64'd2);

        // Newline insertion "x",0A,"y"
        clear_mon();
        pkt[0] = 8'h78; pkt[1] = 8'h0A; pkt[2] = 8'h79;
        run_pkt(3, 0, -1); wait_eop();
        exp_q = '{C_LS, C_X, C_Z, C_LS, C_Y};
        check_seq("nl");
        check_eq("nl_seen", 64'(nl_n), 64'd1);
        check_eq("nl_rdy_low", 64'(nl_rdy), 64'd0);
        check_eq("nl_cnt", 64'(eop_cnt), 64'd3);

        // Trailing newline with s_last: no extra line-start beat
        clear_mon();
        pkt[0] = 8'h78; pkt[1] = 8'h0A;
        run_pkt(2, 0, -1); wait_eop();
        exp_q = '{C_LS, C_X, C_Z};
        check_seq("nl_last");

        // Truncation: six bytes past a limit of four
        clear_mon();
        pkt[0] = 8'h63; pkt[1] = 8'h79; pkt[2] = 8'h63; pkt[3] = 8'h79; pkt[4] = 8'h41; pkt[5] = 8'h42;
        run_pkt(6, 0, -1); wait_eop();
        exp_q = '{C_LS, C_C, C_Y, C_C, C_Y};
        check_seq("trunc");
        check_eq("trunc_flag", 64'(eop_trunc), 64'd1);
        check_eq("trunc_cnt", 64'(eop_cnt), 64'd6);

        // Backpressure: valid every other cycle
        clear_mon();
        pkt[0] = 8'h79; pkt[1] = 8'h63; pkt[2] = 8'h78; pkt[3] = 8'h79;
        run_pkt(4, 1, -1); wait_eop();
        exp_q = '{C_LS, C_Y, C_C, C_X, C_Y};
        check_seq("bp");
        check_eq("bp_cnt", 64'(eop_cnt), 64'd4);
        check_eq("bp_trunc", 64'(eop_trunc), 64'd0);

        // Reset during byte 3 of 8: tail dropped, then a normal packet
        clear_mon();
        for (int i = 0; i < 8; i++) pkt[i] = 8'h63;
        run_pkt(8, 0, 2);
        repeat (6) tick();
        check_eq("drop_sod", 64'(sod_n), 64'd0);
        check_eq("drop_en", 64'(en_n), 64'd0);
        check_eq("drop_eop", 64'(eop_n), 64'd0);
        clear_mon();
        pkt[0] = 8'h78; pkt[1] = 8'h63;
        run_pkt(2, 0, -1); wait_eop();
        exp_q = '{C_LS, C_X, C_C};
        check_seq("post_rst");
        check_eq("post_rst_cnt", 64'(eop_cnt), 64'd2);

        // Single-byte "A": case-fold behaviour on class 7
        clear_mon();
        pkt[0] = 8'h41;
        run_pkt(1, 0, -1); wait_eop();
        exp_q = '{C_LS, C_A};
        check_seq("fold");
        if (en_q.size() > 1) check_eq("fold_cls7", 64'(en_q[1][7]), EXP_C7);
        check_eq("single_cnt", 64'(eop_cnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/payload_char_feeder.md
Name: payload_char_feeder

Overview:
- Front end for the payload engine array. Consumes the payload byte stream from the packet pipeline and produces the per-packet `sod` clear and per-byte `en` strobe.
- Produces the one-hot character-class lines `cls[*]`, which fan out to the `in_*` ports of every engine.
- Inserts virtual line-start beats for multiline `^` anchors.
- Marks end of packet so downstream logic can sample the sticky engine `out` flags.

Parameters:
- NUM_CLASSES, 38, number of class lines. Class 0 is the hardwired line-start symbol; classes 1..NUM_CLASSES-1 come from the class table.
- MAX_BYTES, 1518, payload bytes inspected per packet. Bytes beyond this are consumed but never strobed.
- CNT_W, 16, width of the byte counter.

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- s_data  in  8  payload byte
- s_valid  in  1  byte valid
- s_last  in  1  last byte of packet, qualified by s_valid
- s_ready  out  1  byte accepted when s_valid && s_ready
- cfg_we  in  1  class table write strobe
- cfg_class  in  6  class index to write (1..NUM_CLASSES-1; writes to index 0 are ignored)
- cfg_char  in  8  byte value to write
- cfg_val  in  1  membership bit written
- sod  out  1  start-of-data pulse; drives engine CLR
- en  out  1  engine step strobe
- cls  out  NUM_CLASSES  class lines, valid when en=1
- eop  out  1  end-of-packet pulse; engine outputs are final in this cycle
- trunc  out  1  packet exceeded MAX_BYTES; valid with eop
- byte_cnt  out  CNT_W  bytes accepted in the current packet

Behaviour:
- Reset:
  - Clears FSM (to IDLE), counter, line-start flag and all outputs: sod=0, en=0, cls=0, eop=0, trunc=0, byte_cnt=0, s_ready=0.
  - Class table (256 x NUM_CLASSES-1 bits) is not cleared; it holds its contents across reset.
- Reset mid-packet: the remaining bytes of that packet are dropped until after s_last. Hold a drop flag, which is not cleared by reset; it re-arms on the next s_last.
- All outputs are registered.
- The engine's asynchronous CLR dominates CE, so sod and en must never be high in the same cycle.
- FSM states: IDLE, SOD, LS, DATA, EOP.
  - IDLE:
    - s_ready=0.
    - If s_valid, go to SOD: register sod=1 for exactly one cycle, clear byte_cnt and trunc.
  - SOD:
    - Go to LS.
  - LS (virtual line-start beat):
    - Register en=1, cls=1 (only bit 0 set), s_ready=0.
    - Next state DATA.
  - DATA:
    - s_ready=1.
    - On accept: byte_cnt+1, saturating at all-ones.
    - If byte_cnt < MAX_BYTES before the increment: en=1 and cls[k]=table[k][byte] for k≥1, cls[0]=0.
    - Otherwise: en=0, trunc=1.
    - Next state EOP if s_last.
    - Otherwise next state LS if byte==0x0A and the byte was strobed; drop s_ready for that cycle.
    - Otherwise stay in DATA.
    - No accept: en=0, cls=0.
  - EOP:
    - eop=1 for one cycle; trunc stays valid with it.
    - Next state IDLE, so a back-to-back packet incurs a two-cycle gap before its sod.
  - A 0x0A that is also s_last produces no LS beat.
- Latency: a byte accepted in cycle t appears as en/cls in cycle t+1.
  - sod leads the first LS beat by exactly 1 cycle.
  - eop follows the last en by ≥1 cycle.
- Config writes:
  - Take effect for lookups starting the cycle after cfg_we.
  - A write colliding with a lookup of the same entry returns the old value.
  - Writes are legal in any state.
- Single-byte packet: SOD, LS, DATA (1 byte, s_last), EOP.

Optional Feature:
- Macro: `PAYLOAD_CHAR_FEEDER_CASE_FOLD_EN`.
- When defined, bytes 0x41–0x5A are mapped to 0x61–0x7A before table lookup, so tables are programmed lowercase only. This supports /i rules.
- The newline test and byte_cnt use the raw byte.
- When undefined, the lookup uses the raw byte.

Test Plan:
- Basic packet: load class 5 with 'A' (0x41); send packet "A","B" (s_last on "B") after reset.
  - Required: sod=1 one cycle, then en+cls=0x1 (LS beat), then en with cls[5]=1 for "A", then en with cls=0 for "B", then eop=1, trunc=0, byte_cnt=2.
  - sod never coincides with en.
- Newline insertion: send "x",0x0A,"y".
  - Required: en count = 5 (LS, x, 0A, LS, y); s_ready low the cycle after 0x0A is accepted.
  - Trailing 0x0A with s_last: no extra LS beat.
- Truncation: MAX_BYTES=4, send a 6-byte packet.
  - Required: 5 en pulses (1 LS + 4 bytes); last two bytes accepted with en=0; eop with trunc=1, byte_cnt=6.
- Backpressure and idle: s_valid toggling every other cycle in DATA.
  - Required: en only in cycles after an accept, cls=0 otherwise, no byte lost or duplicated.
- Reset mid-packet: assert reset during byte 3 of 8.
  - Required: all outputs 0 next cycle; table contents preserved.
  - Remaining bytes of that packet dropped; next packet is processed normally with correct class hits.
- Case fold (macro defined): class 7 programmed with 'a' only; send "A".
  - Required: cls[7]=1.
  - With the macro undefined: cls[7]=0.
